pipeline_ctrl: RTL and testbench

Consumer side of the hazard/forwarding interface in the RV32IM 5-stage pipeline. Takes the decode-stage hazard unit's stall/bubble requests, the EX-stage branch redirect and the M-extension divider busy flag. Turns them into per-stage write-enables and flushes for PC, IF/ID, ID/EX and EX/MEM. Sequences the branch-shadow flush and the multi-cycle MDU freeze, and keeps hazard performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 42 ++++
 rtl/pipeline_ctrl_if.sv | 26 ++
 rtl/pipeline_ctrl_perf_counter.sv | 22 ++
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stage controller: FSM state
// encoding, shadow-counter width and the per-stage control bundle.
package pipeline_ctrl_pkg;

  // Encodings are visible on ctrl_state, so they are fixed explicitly.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SHADOW   = 2'd1,
    ST_MDU_WAIT = 2'd2
  } ctrl_state_t;

  // Remaining branch-shadow flush cycles; BR_SHADOW is at most 3.
  localparam int SHADOW_CNT_W = 2;
  typedef logic [SHADOW_CNT_W-1:0] shadow_cnt_t;

  // One cycle's worth of pipeline-register controls.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_flush;
  } stage_ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  localparam stage_ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                         id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};
  // Held in reset: nothing written, every register loads NOP.
  localparam stage_ctrl_t CTRL_RESET  = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                         id_ex_we: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b1};
  // Divider busy: front end frozen, EX/MEM receives a bubble.
  localparam stage_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                         id_ex_we: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1};
  // Taken branch: redirect PC, squash the two younger instructions.
  localparam stage_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                         id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};
  // Branch shadow: fetches still in flight from the old path are squashed.
  localparam stage_ctrl_t CTRL_SHADOW = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                         id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard requests in, per-stage write-enables and flushes out.
// master: the pipeline datapath / hazard unit side. slave: the controller.
interface pipeline_ctrl_if;

  logic stall;
  logic bubble;
  logic branch_taken;
  logic mdu_busy;
  logic pc_we;
  logic if_id_we;
  logic if_id_flush;
  logic id_ex_we;
  logic id_ex_flush;
  logic ex_mem_flush;

  modport master (
    output stall, bubble, branch_taken, mdu_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush
  );

  modport slave (
    input  stall, bubble, branch_taken, mdu_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush
  );

endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Wrapping event counter used for the hazard performance statistics.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per cycle with inc high; wraps modulo 2^W, never saturates.
  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stage controller: turns hazard-unit stall/bubble requests, the
// EX-stage branch redirect and the divider busy flag into per-stage
// write-enables and flushes, sequences the branch shadow and the MDU
// freeze, and counts hazard cycles.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int BR_SHADOW = 0,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  pipeline_ctrl_if.slave     bus,
  output logic [1:0]         ctrl_state,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_cycles,
  output logic [CNT_W-1:0]   mdu_cycles
);

  localparam shadow_cnt_t SHADOW_INIT = shadow_cnt_t'(BR_SHADOW);

  ctrl_state_t state, state_nxt;
  shadow_cnt_t shadow_cnt, shadow_cnt_nxt;
  stage_ctrl_t ctrl;
  logic        stall_inc, flush_inc, mdu_inc;

  // State and shadow-counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      shadow_cnt <= '0;
    end else begin
      state      <= state_nxt;
      shadow_cnt <= shadow_cnt_nxt;
    end
  end

  // Next-state and stage controls; priority mdu_busy > branch > shadow > stall/bubble.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ctrl           = CTRL_NORMAL;
    state_nxt      = state;
    shadow_cnt_nxt = shadow_cnt;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    mdu_inc        = 1'b0;

    if (!reset_n) begin
      ctrl = CTRL_RESET;
    end else if (bus.mdu_busy) begin
      // Freeze everything upstream of EX; the shadow count is preserved so
      // an interrupted branch shadow resumes once the divider finishes.
      ctrl      = CTRL_FREEZE;
      state_nxt = ST_MDU_WAIT;
      mdu_inc   = 1'b1;
    end else if (bus.branch_taken) begin
      ctrl      = CTRL_BRANCH;
      flush_inc = 1'b1;
      if (SHADOW_INIT != '0) begin
        state_nxt      = ST_SHADOW;
        shadow_cnt_nxt = SHADOW_INIT;
      end else begin
        state_nxt = ST_RUN;
      end
    end else if (state == ST_SHADOW) begin
      // ID holds a NOP here, so stall/bubble requests are meaningless.
      ctrl           = CTRL_SHADOW;
      flush_inc      = 1'b1;
      shadow_cnt_nxt = shadow_cnt - 2'd1;
      if (shadow_cnt <= 2'd1) begin
        state_nxt      = ST_RUN;
        shadow_cnt_nxt = '0;
      end
    end else begin
      // RUN, or the first free cycle after a divider freeze (acts as RUN).
      if (bus.stall) begin
        ctrl.pc_we    = 1'b0;
        ctrl.if_id_we = 1'b0;
        ctrl.id_ex_we = 1'b0;
        stall_inc     = 1'b1;
      end
      if (bus.bubble) begin
        ctrl.id_ex_we    = 1'b1;
        ctrl.id_ex_flush = 1'b1;
      end
      if (state == ST_MDU_WAIT) begin
        state_nxt = (shadow_cnt != '0) ? ST_SHADOW : ST_RUN;
      end
    end
  end

  assign bus.pc_we        = ctrl.pc_we;
  assign bus.if_id_we     = ctrl.if_id_we;
  assign bus.if_id_flush  = ctrl.if_id_flush;
  assign bus.id_ex_we     = ctrl.id_ex_we;
  assign bus.id_ex_flush  = ctrl.id_ex_flush;
  assign bus.ex_mem_flush = ctrl.ex_mem_flush;
  assign ctrl_state       = state;

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .count   (stall_cycles)
  );

  perf_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .count   (flush_cycles)
  );

  perf_counter #(.W(CNT_W)) u_mdu_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (mdu_inc),
    .count   (mdu_cycles)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl. dut1: BR_SHADOW=2, CNT_W=32.
// dut2: BR_SHADOW=0, CNT_W=4 (counter wrap and shadow-less branch).
// Each stimulus step pushes the hand-computed expectation for that cycle;
// monitors compare at the falling edge, when inputs and state are stable.
module tb_pipeline_ctrl;

  typedef struct {
    logic [2:0]  we;  // {pc_we, if_id_we, id_ex_we}
    logic [2:0]  fl;  // {if_id_flush, id_ex_flush, ex_mem_flush}
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [31:0] mc;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst2;
  int   total = 0;
  int   bad   = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   n1 = 0;
  int   n2 = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if b1 ();
  pipeline_ctrl_if b2 ();

  logic [1:0]  st1, st2;
  logic [31:0] sc1, fc1, mc1;
  logic [3:0]  sc2, fc2, mc2;

  pipeline_ctrl #(.BR_SHADOW(2), .CNT_W(32)) dut1 (
    .clk          (clk),
    .reset_n      (rst1),
    .bus          (b1.slave),
    .ctrl_state   (st1),
    .stall_cycles (sc1),
    .flush_cycles (fc1),
    .mdu_cycles   (mc1)
  );

  pipeline_ctrl #(.BR_SHADOW(0), .CNT_W(4)) dut2 (
    .clk          (clk),
    .reset_n      (rst2),
    .bus          (b2.slave),
    .ctrl_state   (st2),
    .stall_cycles (sc2),
    .flush_cycles (fc2),
    .mdu_cycles   (mc2)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // dut1 monitor
  always @(negedge clk) begin
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      check("d1_we",    n1, 32'({b1.pc_we, b1.if_id_we, b1.id_ex_we}), 32'(e.we));
      check("d1_flush", n1, 32'({b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush}), 32'(e.fl));
      check("d1_state", n1, 32'(st1), 32'(e.st));
      check("d1_stall_cnt", n1, sc1, e.sc);
      check("d1_flush_cnt", n1, fc1, e.fc);
      check("d1_mdu_cnt",   n1, mc1, e.mc);
      n1++;
    end
  end

  // dut2 monitor
  always @(negedge clk) begin
    if (q2.size() > 0) begin
      exp_t e;
      e = q2.pop_front();
      check("d2_we",    n2, 32'({b2.pc_we, b2.if_id_we, b2.id_ex_we}), 32'(e.we));
      check("d2_flush", n2, 32'({b2.if_id_flush, b2.id_ex_flush, b2.ex_mem_flush}), 32'(e.fl));
      check("d2_state", n2, 32'(st2), 32'(e.st));
      check("d2_stall_cnt", n2, 32'(sc2), e.sc);
      check("d2_flush_cnt", n2, 32'(fc2), e.fc);
      check("d2_mdu_cnt",   n2, 32'(mc2), e.mc);
      n2++;
    end
  end

  // Apply one cycle of stimulus to dut1 and queue what it must show.
  task automatic step1(input logic rn, st, bu, br, md, input logic [2:0] we, fl,
                       input logic [1:0] s, input int sc, fc, mc);
    exp_t e;
    rst1 = rn; b1.stall = st; b1.bubble = bu; b1.branch_taken = br; b1.mdu_busy = md;
    e.we = we; e.fl = fl; e.st = s; e.sc = 32'(sc); e.fc = 32'(fc); e.mc = 32'(mc);
    q1.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic rn, st, bu, br, md, input logic [2:0] we, fl,
                       input logic [1:0] s, input int sc, fc, mc);
    exp_t e;
    rst2 = rn; b2.stall = st; b2.bubble = bu; b2.branch_taken = br; b2.mdu_busy = md;
    e.we = we; e.fl = fl; e.st = s; e.sc = 32'(sc); e.fc = 32'(fc); e.mc = 32'(mc);
    q2.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst1 = 1'b0; b1.stall = 1'b1; b1.bubble = 1'b1; b1.branch_taken = 1'b1; b1.mdu_busy = 1'b1;
    rst2 = 1'b0; b2.stall = 1'b0; b2.bubble = 1'b0; b2.branch_taken = 1'b0; b2.mdu_busy = 1'b0;
    @(posedge clk); #1;

    //     rn st bu br md   we      fl     st  sc fc mc
    // Reset held with all requests high
    step1(0, 1, 1, 1, 1, 3'b000, 3'b111, 0, 0, 0, 0);
    step1(0, 1, 1, 1, 1, 3'b000, 3'b111, 0, 0, 0, 0);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, 0);
    // Load-use, stall alone, bubble alone
    step1(1, 1, 1, 0, 0, 3'b001, 3'b010, 0, 0, 0, 0);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 1, 0, 0);
    step1(1, 1, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 0);
    step1(1, 0, 1, 0, 0, 3'b111, 3'b010, 0, 2, 0, 0);
    // Branch with a 2-cycle shadow; stall/bubble ignored in shadow
    step1(1, 0, 0, 1, 0, 3'b111, 3'b110, 0, 2, 0, 0);
    step1(1, 1, 1, 0, 0, 3'b111, 3'b100, 1, 2, 1, 0);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b100, 1, 2, 2, 0);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 2, 3, 0);
    // Branch again in first shadow cycle restarts the shadow
    step1(1, 0, 0, 1, 0, 3'b111, 3'b110, 0, 2, 3, 0);
    step1(1, 0, 0, 1, 0, 3'b111, 3'b110, 1, 2, 4, 0);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b100, 1, 2, 5, 0);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b100, 1, 2, 6, 0);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 2, 7, 0);
    // Divider busy 5 cycles; stall/branch/bubble ignored
    step1(1, 0, 0, 0, 1, 3'b000, 3'b001, 0, 2, 7, 0);
    step1(1, 1, 0, 0, 1, 3'b000, 3'b001, 2, 2, 7, 1);
    step1(1, 1, 0, 1, 1, 3'b000, 3'b001, 2, 2, 7, 2);
    step1(1, 0, 1, 0, 1, 3'b000, 3'b001, 2, 2, 7, 3);
    step1(1, 0, 0, 0, 1, 3'b000, 3'b001, 2, 2, 7, 4);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b000, 2, 2, 7, 5);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 2, 7, 5);
    // Divider interrupts a shadow; shadow resumes with its remaining cycle
    step1(1, 0, 0, 1, 0, 3'b111, 3'b110, 0, 2, 7, 5);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b100, 1, 2, 8, 5);
    step1(1, 0, 0, 0, 1, 3'b000, 3'b001, 1, 2, 9, 5);
    step1(1, 1, 0, 0, 0, 3'b000, 3'b000, 2, 2, 9, 6);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b100, 1, 3, 9, 6);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 3, 10, 6);
    // Mid-run reset clears state and counters
    step1(0, 0, 0, 0, 0, 3'b000, 3'b111, 0, 3, 10, 6);
    step1(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, 0);
    rst1 = 1'b1; b1.stall = 1'b0; b1.bubble = 1'b0; b1.branch_taken = 1'b0; b1.mdu_busy = 1'b0;

    // dut2: 17 stalls wrap the 4-bit counter to 1, then a shadow-less branch
    for (int k = 0; k < 17; k++) begin
      step2(1, 1, 0, 0, 0, 3'b000, 3'b000, 0, k % 16, 0, 0);
    end
    step2(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 1, 0, 0);
    step2(1, 0, 0, 1, 0, 3'b111, 3'b110, 0, 1, 0, 0);
    step2(1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 1, 1, 0);

    // Let the monitors drain their queues, bounded.
    for (int i = 0; i < 4; i++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(negedge clk); #1;
    end
    check("queue_drain", 0, 32'(q1.size() + q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
